// File: rtl/kernel_bank_loader.sv
// kernel_bank_loader: stages weights into a shadow bank, publishes them to the
// active bank on a checked commit, and buffers the pixel stream in a 2-entry FIFO.
module kernel_bank_loader #(
  parameter int unsigned DW     = 8,
  parameter int unsigned K_SIZE = 25,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned AW     = (K_SIZE > 1) ? $clog2(K_SIZE) : 1,
  parameter int unsigned CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic [DW-1:0]              iX,
  input  logic                       iValid,
  output logic                       oReady,
  output logic [DW-1:0]              oX,
  output logic                       oXValid,
  input  logic                       iXReady,
  input  logic [DW-1:0]              iW,
  input  logic                       iWren,
  input  logic                       iAuto,
  input  logic [CW-1:0]              iCH,
  input  logic [AW-1:0]              iADDR,
  input  logic                       iCommit,
  output logic [DW*K_SIZE*N_CH-1:0]  oKernel,
  output logic                       oLoadDone,
  output logic                       oCommitAck,
  output logic                       oErr
);

  localparam int unsigned NE = K_SIZE * N_CH;
  localparam int unsigned IW = (NE > 1) ? $clog2(NE) : 1;

  logic [DW-1:0] r_shadow [NE];
  logic [DW-1:0] r_active [NE];
  logic [NE-1:0] r_mask;
  logic [NE-1:0] w_mask_nxt;
  logic [CW-1:0] r_ptr_ch;
  logic [CW-1:0] w_ptr_ch_nxt;
  logic [CW-1:0] w_ch;
  logic [AW-1:0] r_ptr_tap;
  logic [AW-1:0] w_ptr_tap_nxt;
  logic [AW-1:0] w_tap;
  logic [IW-1:0] w_idx;
  logic          w_in_range;
  logic          w_wr_ok;
  logic          w_full;
  logic          w_commit_ok;
  logic          r_load_done;
  logic          r_commit_ack;
  logic          r_err;

  logic [DW-1:0] r_x0;
  logic [DW-1:0] r_x1;
  logic [1:0]    r_cnt;
  logic          w_push;
  logic          w_pop;

  // Write target decode, commit qualification and next mask / pointer.
  always_comb begin
    w_ch          = iAuto ? r_ptr_ch : iCH;
    w_tap         = iAuto ? r_ptr_tap : iADDR;
    w_in_range    = (32'(w_ch) < N_CH) && (32'(w_tap) < K_SIZE);
    w_idx         = IW'(32'(w_ch) * K_SIZE + 32'(w_tap));
    w_wr_ok       = iWren && w_in_range;
    w_full        = &r_mask;
    w_commit_ok   = iCommit && w_full;
    w_ptr_ch_nxt  = r_ptr_ch;
    w_ptr_tap_nxt = r_ptr_tap;
    // Commit clears the mask first so a same-cycle write re-marks its entry.
    w_mask_nxt    = w_commit_ok ? '0 : r_mask;
    if (w_wr_ok) begin
      w_mask_nxt[w_idx] = 1'b1;
    end
    if (w_commit_ok) begin
      w_ptr_ch_nxt  = '0;
      w_ptr_tap_nxt = '0;
    end else if (iWren && iAuto) begin
      if (32'(r_ptr_tap) == K_SIZE - 1) begin
        w_ptr_tap_nxt = '0;
        w_ptr_ch_nxt  = (32'(r_ptr_ch) == N_CH - 1) ? '0 : r_ptr_ch + CW'(1);
      end else begin
        w_ptr_tap_nxt = r_ptr_tap + AW'(1);
      end
    end
  end

  // Weight banks, mask, pointer and status pulses.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < int'(NE); i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_mask       <= '0;
      r_ptr_ch     <= '0;
      r_ptr_tap    <= '0;
      r_load_done  <= 1'b0;
      r_commit_ack <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_shadow[w_idx] <= iW;
      end
      if (w_commit_ok) begin
        r_active <= r_shadow;
      end
      r_mask       <= w_mask_nxt;
      r_ptr_ch     <= w_ptr_ch_nxt;
      r_ptr_tap    <= w_ptr_tap_nxt;
      r_load_done  <= &r_mask;
      r_commit_ack <= w_commit_ok;
      r_err        <= (iWren && !w_in_range) || (iCommit && !w_full);
    end
  end

  for (genvar g = 0; g < int'(NE); g++) begin : g_kernel
    assign oKernel[g*DW +: DW] = r_active[g];
  end

  assign oLoadDone  = r_load_done;
  assign oCommitAck = r_commit_ack;
  assign oErr       = r_err;

  // Pixel FIFO: r_x0 is the head and drives oX directly.
  assign oReady  = !iRST && (r_cnt != 2'd2);
  assign w_push  = iValid && oReady;
  assign w_pop   = (r_cnt != 2'd0) && iXReady;
  assign oXValid = (r_cnt != 2'd0);
  assign oX      = r_x0;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_x0  <= '0;
      r_x1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (w_push) begin
            r_x0  <= iX;
            r_cnt <= 2'd1;
          end
        end
        2'd1: begin
          case ({w_push, w_pop})
            2'b10: begin
              r_x1  <= iX;
              r_cnt <= 2'd2;
            end
            2'b01:   r_cnt <= 2'd0;
            2'b11:   r_x0  <= iX;
            default: r_cnt <= 2'd1;
          endcase
        end
        2'd2: begin
          if (w_pop) begin
            r_x0  <= r_x1;
            r_cnt <= 2'd1;
          end
        end
        default: r_cnt <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_bank_loader.sv
// Randomized scoreboard bench for kernel_bank_loader: stimulus queues expected
// commit/error/pixel events, a negedge monitor pops and compares them.
module tb_kernel_bank_loader;

  localparam int unsigned DW = 8;
  localparam int unsigned K  = 25;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 3;
  localparam int unsigned NE = K * N;
  localparam int unsigned KW = DW * NE;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic [DW-1:0] iX = '0;
  logic          iValid = 1'b0;
  logic          oReady;
  logic [DW-1:0] oX;
  logic          oXValid;
  logic          iXReady = 1'b1;
  logic [DW-1:0] iW = '0;
  logic          iWren = 1'b0;
  logic          iAuto = 1'b0;
  logic [CW-1:0] iCH = '0;
  logic [AW-1:0] iADDR = '0;
  logic          iCommit = 1'b0;
  logic [KW-1:0] oKernel;
  logic          oLoadDone;
  logic          oCommitAck;
  logic          oErr;

  kernel_bank_loader #(.DW(DW), .K_SIZE(K), .N_CH(N), .AW(AW), .CW(CW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iX(iX), .iValid(iValid), .oReady(oReady),
    .oX(oX), .oXValid(oXValid), .iXReady(iXReady), .iW(iW), .iWren(iWren),
    .iAuto(iAuto), .iCH(iCH), .iADDR(iADDR), .iCommit(iCommit),
    .oKernel(oKernel), .oLoadDone(oLoadDone), .oCommitAck(oCommitAck), .oErr(oErr)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit mon_en = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  // Reference model: flat entry index = ch*K + tap, pointer as a linear count.
  logic [DW-1:0] m_sh  [NE];
  logic [DW-1:0] m_act [NE];
  bit            m_mask[NE];
  int            m_ptr;
  int            occ;

  typedef struct {
    int            c;
    logic [KW-1:0] k;
  } ack_t;

  ack_t          q_ack[$];
  int            q_err[$];
  logic [DW-1:0] q_pix[$];

  function automatic logic [KW-1:0] act_flat();
    logic [KW-1:0] f;
    for (int i = 0; i < int'(NE); i++) f[i*DW +: DW] = m_act[i];
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < int'(NE); i++) begin
      m_sh[i]   = '0;
      m_act[i]  = '0;
      m_mask[i] = 0;
    end
    m_ptr = 0;
    occ   = 0;
    q_pix.delete();
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic cmp_kernel(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    int bad;
    bad = -1;
    for (int i = int'(NE) - 1; i >= 0; i--)
      if (act[i*DW +: DW] !== exp[i*DW +: DW]) bad = i;
    checks++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s ch%0d tap%0d got=%0h want=%0h", nm, bad / int'(K), bad % int'(K),
               act[bad*DW +: DW], exp[bad*DW +: DW]);
    end
  endtask

  // One weight-port cycle; the model applies commit before the write.
  task automatic wcycle(input logic wr, input logic au, input int ch, input int ad,
                        input logic [DW-1:0] w, input logic cm);
    int e;
    int t;
    bit full;
    bit ok;
    bit err;
    iWren = wr; iAuto = au; iCH = CW'(ch); iADDR = AW'(ad); iW = w; iCommit = cm;
    e = cyc + 1;
    full = 1;
    for (int i = 0; i < int'(NE); i++) if (!m_mask[i]) full = 0;
    ok  = cm && full;
    err = cm && !full;
    if (ok) begin
      m_act = m_sh;
      for (int i = 0; i < int'(NE); i++) m_mask[i] = 0;
      q_ack.push_back('{e, act_flat()});
    end
    if (wr) begin
      if (!au && (ch >= int'(N) || ad >= int'(K))) err = 1;
      else begin
        t = au ? m_ptr : ch * int'(K) + ad;
        m_sh[t]   = w;
        m_mask[t] = 1;
      end
      if (au) m_ptr = (m_ptr + 1) % int'(NE);
    end
    if (ok) m_ptr = 0;
    if (err) q_err.push_back(e);
    @(posedge iCLK); #1;
    iWren = 1'b0; iCommit = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iCLK); #1;
    end
  endtask

  // One pixel-port cycle; the occupancy model decides acceptance and oReady.
  task automatic pix_cycle(input logic v, input logic [DW-1:0] x, input logic xr, output bit acc);
    bit pop;
    iValid = v; iX = x; iXReady = xr;
    #1;
    chk("pix_ready", oReady, (occ < 2));
    acc = v && (occ < 2);
    pop = xr && (occ > 0);
    if (acc) q_pix.push_back(x);
    occ = occ + int'(acc) - int'(pop);
    @(posedge iCLK); #1;
  endtask

  ack_t          mon_a;
  bit            stall_v = 0;
  logic [DW-1:0] stall_x;
  logic [DW-1:0] mon_px;

  always @(negedge iCLK) begin
    if (mon_en) begin
      if (oErr === 1'b1) begin
        checks++;
        if (q_err.size() > 0 && q_err[0] == cyc) void'(q_err.pop_front());
        else begin
          fails++;
          $display("FAIL err_pulse got=1 want=0 cycle=%0d", cyc);
        end
      end else if (q_err.size() > 0 && q_err[0] <= cyc) begin
        checks++; fails++;
        $display("FAIL err_pulse got=0 want=1 cycle=%0d", q_err[0]);
        void'(q_err.pop_front());
      end
      if (oCommitAck === 1'b1) begin
        if (q_ack.size() > 0 && q_ack[0].c == cyc) begin
          mon_a = q_ack.pop_front();
          cmp_kernel("commit_kernel", oKernel, mon_a.k);
        end else begin
          checks++; fails++;
          $display("FAIL commit_ack got=1 want=0 cycle=%0d", cyc);
        end
      end else if (q_ack.size() > 0 && q_ack[0].c <= cyc) begin
        checks++; fails++;
        $display("FAIL commit_ack got=0 want=1 cycle=%0d", q_ack[0].c);
        void'(q_ack.pop_front());
      end
      if (iRST) stall_v = 0;
      else begin
        if (stall_v) begin
          checks++;
          if (oXValid !== 1'b1 || oX !== stall_x) begin
            fails++;
            $display("FAIL ox_stable got=%0h/%0b want=%0h/1", oX, oXValid, stall_x);
          end
        end
        if (oXValid === 1'b1 && iXReady) begin
          checks++;
          if (q_pix.size() == 0) begin
            fails++;
            $display("FAIL pix_out got=%0h want=none", oX);
          end else begin
            mon_px = q_pix.pop_front();
            if (oX !== mon_px) begin
              fails++;
              $display("FAIL pix_out got=%0h want=%0h", oX, mon_px);
            end
          end
        end
        stall_v = (oXValid === 1'b1) && !iXReady;
        stall_x = oX;
      end
    end
  end

  int            skip;
  int            sent;
  int            j;
  bit            acc;
  logic [DW-1:0] rx;

  initial begin
    model_clear();
    iRST = 1'b1;
    repeat (2) @(posedge iCLK);
    #1;
    chk("rst_ready", oReady, 0);
    chk("rst_xvalid", oXValid, 0);
    chk("rst_x", oX, 0);
    chk("rst_loaddone", oLoadDone, 0);
    chk("rst_ack", oCommitAck, 0);
    chk("rst_err", oErr, 0);
    cmp_kernel("rst_kernel", oKernel, '0);
    iRST = 1'b0;
    #1;
    chk("ready_after_rst", oReady, 1);
    mon_en = 1;

    // Auto-load i-50 into all entries, then commit.
    for (int i = 0; i < int'(NE); i++) wcycle(1, 1, 0, 0, DW'(i - 50), 0);
    chk("loaddone_lag", oLoadDone, 0);
    wcycle(0, 0, 0, 0, '0, 1);
    chk("loaddone", oLoadDone, 1);
    idle(2);
    cmp_kernel("kernel_autoload", oKernel, act_flat());

    // Incomplete load: one entry missing, commit must be rejected.
    skip = $urandom_range(0, NE - 1);
    for (int i = 0; i < int'(NE); i++)
      if (i != skip) wcycle(1, 0, i / int'(K), i % int'(K), DW'($urandom), 0);
    wcycle(0, 0, 0, 0, '0, 1);
    idle(2);
    cmp_kernel("kernel_after_reject", oKernel, act_flat());

    // Out-of-range explicit writes must not disturb shadow or mask.
    wcycle(1, 0, 0, 25, 8'h11, 0);
    wcycle(1, 0, 4, 0, 8'h22, 0);
    wcycle(1, 0, skip / int'(K), skip % int'(K), DW'($urandom), 0);
    wcycle(0, 0, 0, 0, '0, 1);
    idle(2);

    // Same-cycle write + commit publishes the pre-write entry (0,0).
    wcycle(1, 0, 0, 0, 8'h01, 0);
    for (int i = 1; i < int'(NE); i++) wcycle(1, 0, i / int'(K), i % int'(K), DW'($urandom), 0);
    wcycle(1, 0, 0, 0, 8'h7F, 1);
    idle(2);
    chk("simul_old_tap00", oKernel[DW-1:0], 8'h01);
    for (int i = 1; i < int'(NE); i++) wcycle(1, 0, i / int'(K), i % int'(K), DW'($urandom), 0);
    wcycle(0, 0, 0, 0, '0, 1);
    idle(2);
    chk("simul_new_tap00", oKernel[DW-1:0], 8'h7F);

    // Pixel backpressure: 1..5 with iXReady low for cycles 2-4.
    sent = 0;
    j = 0;
    while ((sent < 5 || occ > 0) && j < 30) begin
      pix_cycle(sent < 5, DW'(sent + 1), !(j >= 2 && j <= 4), acc);
      if (acc) sent++;
      j++;
    end
    chk("bp_bound", (j >= 30), 0);

    // Randomized pixel traffic followed by a drain.
    for (int i = 0; i < 300; i++) begin
      rx = DW'($urandom);
      pix_cycle($urandom_range(0, 1) == 1, rx, $urandom_range(0, 3) != 0, acc);
    end
    j = 0;
    while (occ > 0 && j < 10) begin
      pix_cycle(1'b0, '0, 1'b1, acc);
      j++;
    end
    chk("drain_bound", (j >= 10), 0);

    // Reset with one pixel buffered and 50 weights written.
    pix_cycle(1'b1, 8'hA5, 1'b0, acc);
    iValid = 1'b0;
    for (int i = 0; i < 50; i++) wcycle(1, 1, 0, 0, DW'($urandom), 0);
    iRST = 1'b1;
    model_clear();
    @(posedge iCLK); #1;
    iRST = 1'b0;
    #1;
    chk("midrst_xvalid", oXValid, 0);
    chk("midrst_loaddone", oLoadDone, 0);
    chk("midrst_ready", oReady, 1);
    cmp_kernel("midrst_kernel", oKernel, '0);
    iXReady = 1'b1;
    for (int i = 0; i < int'(NE); i++) wcycle(1, 1, 0, 0, DW'($urandom), 0);
    wcycle(0, 0, 0, 0, '0, 1);
    idle(3);
    cmp_kernel("kernel_after_midrst_load", oKernel, act_flat());

    chk("q_err_empty", q_err.size(), 0);
    chk("q_ack_empty", q_ack.size(), 0);
    chk("q_pix_empty", q_pix.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
